// File: rtl/ov7670_frame_writer.sv
// rtl/ov7670_frame_writer.sv - OV7670 capture, RGB565 assembly, 4x4 decimation into BRAM port A
// Camera signals are oversampled in the CLK_25M domain; PCLK rising edges act as byte strobes.
module ov7670_frame_writer #(
  parameter int IN_WIDTH    = 640,
  parameter int IN_HEIGHT   = 480,
  parameter int DECIM_SHIFT = 2,
  parameter int OUT_WIDTH   = IN_WIDTH >> DECIM_SHIFT
) (
  input  logic        CLK_25M,
  input  logic        RST,
  input  logic        cam_pclk,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  input  logic        capture_en,
  output logic [15:0] addra,
  output logic [15:0] dina,
  output logic        wea,
  output logic        ena,
  output logic        frame_done,
  output logic [7:0]  frame_cnt,
  output logic        line_len_err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, WAIT_VS, WAIT_START, CAPTURE} state_t;

  localparam logic [9:0] X_LIM = 10'(IN_WIDTH);
  localparam logic [8:0] Y_LIM = 9'(IN_HEIGHT);

  state_t      state;
  logic [2:0]  pclk_sr, vs_sr, href_sr;
  logic [7:0]  data_s1, data_s2;
  logic [7:0]  hi_byte;
  logic        phase;
  logic [9:0]  x;
  logic [8:0]  y;
  logic [15:0] addr_full;
  logic        pclk_rise, vs_rise, vs_fall, href_s, href_fall, store_ok;

  // Stage [1] is the synchronized level, stage [2] its previous value.
  always_ff @(posedge CLK_25M or posedge RST) begin
    if (RST) begin
      pclk_sr <= '0;
      vs_sr   <= '0;
      href_sr <= '0;
      data_s1 <= '0;
      data_s2 <= '0;
    end else begin
      pclk_sr <= {pclk_sr[1:0], cam_pclk};
      vs_sr   <= {vs_sr[1:0], cam_vsync};
      href_sr <= {href_sr[1:0], cam_href};
      data_s1 <= cam_data;
      data_s2 <= data_s1;
    end
  end

  assign pclk_rise = pclk_sr[1] & ~pclk_sr[2];
  assign vs_rise   = vs_sr[1] & ~vs_sr[2];
  assign vs_fall   = ~vs_sr[1] & vs_sr[2];
  assign href_s    = href_sr[1];
  assign href_fall = ~href_sr[1] & href_sr[2];

  always_comb begin
    addr_full = 16'(x >> DECIM_SHIFT) + 16'(y >> DECIM_SHIFT) * 16'(OUT_WIDTH);
    store_ok  = (x[DECIM_SHIFT-1:0] == '0) && (y[DECIM_SHIFT-1:0] == '0) &&
                (x < X_LIM) && (y < Y_LIM);
  end

  assign ena = wea;

  always_ff @(posedge CLK_25M or posedge RST) begin
    if (RST) begin
      state        <= IDLE;
      addra        <= '0;
      dina         <= '0;
      wea          <= 1'b0;
      frame_done   <= 1'b0;
      frame_cnt    <= '0;
      line_len_err <= 1'b0;
      busy         <= 1'b0;
      hi_byte      <= '0;
      phase        <= 1'b0;
      x            <= '0;
      y            <= '0;
    end else begin
      wea        <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (capture_en) state <= WAIT_VS;
        end
        WAIT_VS: begin
          if (!capture_en) begin
            state <= IDLE;
          end else if (vs_rise) begin
            state <= WAIT_START;
            busy  <= 1'b1;
          end
        end
        WAIT_START: begin
          if (!capture_en) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (vs_fall) begin
            x            <= '0;
            y            <= '0;
            phase        <= 1'b0;
            line_len_err <= 1'b0;
            state        <= CAPTURE;
          end
        end
        CAPTURE: begin
          // The frame always runs to the next VSYNC rise, even if capture_en drops.
          if (vs_rise) begin
            frame_done <= 1'b1;
            frame_cnt  <= frame_cnt + 8'd1;
            state      <= capture_en ? WAIT_START : IDLE;
            busy       <= capture_en;
          end
          if (!href_s) begin
            phase <= 1'b0;
          end else if (pclk_rise) begin
            if (!phase) begin
              hi_byte <= data_s2;
              phase   <= 1'b1;
            end else begin
              phase <= 1'b0;
              if (store_ok) begin
                wea   <= 1'b1;
                addra <= addr_full;
                dina  <= {hi_byte, data_s2};
              end
              if (x != '1) x <= x + 10'd1;
            end
          end
          // A dangling high byte at line end is dropped and flagged.
          if (href_fall) begin
            if (x != X_LIM || phase) line_len_err <= 1'b1;
            if (x != '0 && y != '1) y <= y + 9'd1;
            x <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ov7670_frame_writer.sv
// tb/tb_ov7670_frame_writer.sv - directed bench for ov7670_frame_writer on a 16x8 geometry
module tb_ov7670_frame_writer;
  localparam int W = 16, H = 8, S = 2, OW = W >> S;

  logic        CLK_25M = 1'b0;
  logic        RST = 1'b1;
  logic        cam_pclk = 1'b0, cam_vsync = 1'b0, cam_href = 1'b0;
  logic [7:0]  cam_data = '0;
  logic        capture_en = 1'b0;
  logic [15:0] addra, dina;
  logic        wea, ena, frame_done, line_len_err, busy;
  logic [7:0]  frame_cnt;

  ov7670_frame_writer #(.IN_WIDTH(W), .IN_HEIGHT(H), .DECIM_SHIFT(S), .OUT_WIDTH(OW)) dut (
    .CLK_25M(CLK_25M), .RST(RST), .cam_pclk(cam_pclk), .cam_vsync(cam_vsync),
    .cam_href(cam_href), .cam_data(cam_data), .capture_en(capture_en),
    .addra(addra), .dina(dina), .wea(wea), .ena(ena), .frame_done(frame_done),
    .frame_cnt(frame_cnt), .line_len_err(line_len_err), .busy(busy)
  );

  always #20 CLK_25M = ~CLK_25M;

  typedef struct {
    int lines; int npix; int bad_line; int bad_pix; int extra;
    int exp_wr; int exp_err; int exp_max;
  } vec_t;

  vec_t vecs[8];
  int total = 0, bad = 0;
  int wr_cnt, done_cnt, max_addr, dup_cnt, err_at_done, exp_fc;
  int hits[0:63];

  function automatic logic [15:0] pix(int px, int py);
    return {5'(py), 6'(px), 5'b0};
  endfunction

  task automatic check(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_sb();
    wr_cnt = 0; done_cnt = 0; max_addr = -1; dup_cnt = 0; err_at_done = -1;
    for (int i = 0; i < 64; i++) hits[i] = 0;
  endtask

  // Write monitor: every stored word must carry the pixel at its decimated coordinate.
  always @(negedge CLK_25M) begin
    int a;
    logic [15:0] ep;
    if (wea || ena) begin
      total++;
      if (wea !== ena) begin
        bad++;
        $display("FAIL ena_eq_wea: ena=%0b wea=%0b", ena, wea);
      end
    end
    if (wea) begin
      wr_cnt++;
      a = int'(addra);
      if (a > max_addr) max_addr = a;
      if (a < 64) begin
        if (hits[a] != 0) dup_cnt++;
        hits[a]++;
      end
      ep = pix((a % OW) << S, (a / OW) << S);
      total++;
      if (dina !== ep) begin
        bad++;
        $display("FAIL dina@%0d: got %h expected %h", a, dina, ep);
      end
    end
    if (frame_done) begin
      done_cnt++;
      err_at_done = int'(line_len_err);
    end
  end

  task automatic pclk_cycle();
    #80 cam_pclk = 1'b1;
    #80 cam_pclk = 1'b0;
  endtask

  task automatic do_event(int kind);
    if (kind == 1) capture_en = 1'b1;
    if (kind == 2) capture_en = 1'b0;
    if (kind == 3) begin
      RST = 1'b1;
      #1;
      check("rst_mid_addra", int'(addra), 0);
      check("rst_mid_wea", int'(wea), 0);
      check("rst_mid_frame_cnt", int'(frame_cnt), 0);
      check("rst_mid_busy", int'(busy), 0);
      check("rst_mid_dina", int'(dina), 0);
      #79 RST = 1'b0;
      clear_sb();
      exp_fc = 0;
    end
  endtask

  // Lines of a frame followed by the VSYNC pulse that ends it and opens the next.
  task automatic send_frame(int lines, int npix, int bad_line, int bad_pix, int extra,
                            int ev_line, int ev_kind);
    logic [15:0] p;
    int np;
    repeat (2) pclk_cycle();
    for (int ly = 0; ly < lines; ly++) begin
      if (ly == ev_line) do_event(ev_kind);
      np = (ly == bad_line) ? bad_pix : npix;
      cam_href = 1'b1;
      for (int lx = 0; lx < np; lx++) begin
        p = pix(lx, ly);
        cam_data = p[15:8];
        pclk_cycle();
        cam_data = p[7:0];
        pclk_cycle();
      end
      if (ly == bad_line && extra != 0) begin
        cam_data = 8'hAA;
        pclk_cycle();
      end
      cam_href = 1'b0;
      repeat (2) pclk_cycle();
    end
    cam_vsync = 1'b1;
    repeat (3) pclk_cycle();
    cam_vsync = 1'b0;
    repeat (3) pclk_cycle();
  endtask

  initial begin
    vecs[0] = '{8, 16, -1, 0, 0, 8, 0, 7};
    vecs[1] = '{8, 16, 3, 15, 0, 8, 1, 7};
    vecs[2] = '{8, 16, 4, 16, 1, 8, 1, 7};
    vecs[3] = '{8, 16, 0, 17, 0, 8, 1, 7};
    vecs[4] = '{8, 16, 4, 3, 0, 5, 1, 4};
    vecs[5] = '{10, 20, -1, 0, 0, 8, 1, 7};
    vecs[6] = '{4, 16, -1, 0, 0, 4, 0, 3};
    vecs[7] = '{8, 16, -1, 0, 0, 8, 0, 7};
    exp_fc = 0;
    clear_sb();

    #105;
    check("reset_addra", int'(addra), 0);
    check("reset_dina", int'(dina), 0);
    check("reset_wea", int'(wea), 0);
    check("reset_ena", int'(ena), 0);
    check("reset_frame_done", int'(frame_done), 0);
    check("reset_frame_cnt", int'(frame_cnt), 0);
    check("reset_line_len_err", int'(line_len_err), 0);
    check("reset_busy", int'(busy), 0);
    RST = 1'b0;
    #80;

    clear_sb();
    send_frame(8, 16, -1, 0, 0, 3, 1);
    check("midenable_writes", wr_cnt, 0);
    check("midenable_done", done_cnt, 0);

    for (int i = 0; i < 8; i++) begin
      clear_sb();
      send_frame(vecs[i].lines, vecs[i].npix, vecs[i].bad_line, vecs[i].bad_pix,
                 vecs[i].extra, -1, 0);
      exp_fc++;
      check($sformatf("v%0d_writes", i), wr_cnt, vecs[i].exp_wr);
      check($sformatf("v%0d_err", i), err_at_done, vecs[i].exp_err);
      check($sformatf("v%0d_done", i), done_cnt, 1);
      check($sformatf("v%0d_max_addr", i), max_addr, vecs[i].exp_max);
      check($sformatf("v%0d_dup", i), dup_cnt, 0);
      check($sformatf("v%0d_frame_cnt", i), int'(frame_cnt), exp_fc);
      check($sformatf("v%0d_busy", i), int'(busy), 1);
    end

    clear_sb();
    send_frame(8, 16, -1, 0, 0, 3, 3);
    check("rst_after_writes", wr_cnt, 0);
    check("rst_after_done", done_cnt, 0);
    clear_sb();
    send_frame(8, 16, -1, 0, 0, -1, 0);
    exp_fc++;
    check("rst_next_writes", wr_cnt, 8);
    check("rst_next_frame_cnt", int'(frame_cnt), exp_fc);
    check("rst_next_max_addr", max_addr, 7);

    clear_sb();
    send_frame(8, 16, -1, 0, 0, 4, 2);
    exp_fc++;
    check("disable_writes", wr_cnt, 8);
    check("disable_done", done_cnt, 1);
    check("disable_busy", int'(busy), 0);
    clear_sb();
    send_frame(8, 16, -1, 0, 0, -1, 0);
    check("idle_writes", wr_cnt, 0);
    check("idle_done", done_cnt, 0);
    check("idle_frame_cnt", int'(frame_cnt), exp_fc);
    check("idle_busy", int'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ov7670_frame_writer.md
Name: ov7670_frame_writer

Overview:
Write-side counterpart of the display frame-buffer reader. Captures the OV7670 8-bit parallel stream (PCLK/HREF/VSYNC/D[7:0]) in the CLK_25M domain and assembles RGB565 pixels. Decimates the 640x480 input by 4 in each axis and writes the 160x120 result into BRAM port A. The display side reads the same buffer at address x/4 + (y/4)*160.

Parameters:
IN_WIDTH, 640, input pixels per line (HREF-high pixels expected)
IN_HEIGHT, 480, input lines per frame
DECIM_SHIFT, 2, log2 decimation factor in both axes
OUT_WIDTH, 160, output line pitch in words (IN_WIDTH >> DECIM_SHIFT)

Ports:
CLK_25M  in  1  system/pixel clock; reset RST, asynchronous, active-high; clock CLK_25M
RST  in  1  asynchronous active-high reset
cam_pclk  in  1  camera pixel clock, asynchronous, sampled as data
cam_vsync  in  1  camera VSYNC, high = vertical blank
cam_href  in  1  camera HREF, high = valid bytes
cam_data  in  8  camera data bus
capture_en  in  1  level; 1 = capture frames continuously
addra  out  16  BRAM port A address
dina  out  16  RGB565 write data {R[4:0],G[5:0],B[4:0]}
wea  out  1  write strobe, one CLK_25M cycle per stored pixel
ena  out  1  port enable, equal to wea
frame_done  out  1  one-cycle pulse at the end of each captured frame
frame_cnt  out  8  captured-frame counter, wraps 255->0
line_len_err  out  1  sticky per frame; set on a bad line length
busy  out  1  high in WAIT_START or CAPTURE

Behaviour:
- Input sampling: cam_pclk, cam_vsync, cam_href and cam_data each pass through an identical 2-FF synchronizer, plus a third register for edge detection. The PCLK rising edge (sync=1, prev=0) is the byte strobe. Data and HREF are taken from the same pipeline stage as the detected edge.
- Requirement: cam_pclk <= 6.25 MHz, with each level >= 2 CLK_25M periods. Faster PCLK is unsupported.
- VSYNC rise/fall are detected from the synchronized signal in the same way.
- FSM states:
  - IDLE: waits for capture_en=1, then goes to WAIT_VS.
  - WAIT_VS: waits for a VSYNC rising edge, then goes to WAIT_START. This ensures capture never begins mid-frame.
  - WAIT_START: on a VSYNC falling edge, clears x/y counters and line_len_err, then goes to CAPTURE.
  - CAPTURE: on a VSYNC rising edge, pulses frame_done, increments frame_cnt, then goes to WAIT_START if capture_en=1, else IDLE.
- Deasserting capture_en mid-frame does not abort the frame; it is completed.
- Byte assembly: in CAPTURE, each PCLK rise with HREF=1 toggles the byte phase.
  - Phase 0 latches the high byte (RRRRRGGG).
  - Phase 1 forms the pixel {hi, byte}.
  - Phase resets to 0 whenever HREF=0.
- x counter (10b): increments on each completed pixel; cleared on HREF falling edge.
- y counter (9b): increments on HREF falling edge when x>0; cleared at frame start.
- Store rule: write when x[DECIM_SHIFT-1:0]==0, y[DECIM_SHIFT-1:0]==0, x<IN_WIDTH and y<IN_HEIGHT.
  - addra = (x>>DECIM_SHIFT) + (y>>DECIM_SHIFT)*OUT_WIDTH.
  - Computed at full width, truncated to 16b; max address 19199.
- Write latency: wea/ena high for exactly 1 cycle, in the cycle after the detected PCLK edge that completed the pixel. dina/addra are valid in that cycle and hold until the next write.
- Boundary conditions:
  - Pixels with x>=IN_WIDTH or lines with y>=IN_HEIGHT are dropped, with no write and no wrap.
  - line_len_err is set when HREF falls with x != IN_WIDTH or with byte phase=1 (dangling byte is discarded).
  - A VSYNC rise in CAPTURE while HREF=1 still ends the frame normally.
  - No writes occur outside CAPTURE.
- Reset: all outputs 0 (addra, dina, wea, ena, frame_done, frame_cnt, line_len_err, busy); FSM to IDLE; synchronizers and counters cleared.
  - Reset mid-frame discards partial state.
  - After release, the first write occurs only after a full VSYNC rise/fall sequence.

Test Plan:
1. Full frame: capture_en=1, camera model sends VSYNC pulse then 480 lines x 1280 bytes, pixel value = {y[4:0], x[5:0], 5'b0}, PCLK 6.25 MHz -> exactly 19200 wea pulses, addra 0..19199 each once, dina at addr 161 equals pixel (x=4, y=4), one frame_done, frame_cnt=1.
2. Mid-frame enable: assert capture_en during line 200 -> no writes until the next VSYNC rise then fall; the following frame is complete (19200 writes).
3. Short line: line 8 has 639 pixels, or an odd byte count -> line_len_err=1 after HREF fall; stays 1 until the next frame start; no write for any dangling byte.
4. Oversize frame: 500 lines x 700 pixels -> writes only for x<640 and y<480, max addra 19199, no address beyond.
5. Reset mid-frame: assert RST at line 100 -> all outputs 0 in the same cycle (async); after release, no write until a fresh VSYNC rise/fall; the next frame is complete.
6. Disable mid-frame: capture_en=0 at line 240 -> the frame completes (19200 writes), frame_done pulses, FSM returns to IDLE, busy=0, no further writes.
